// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, LFSR step helpers and FSM state type for vga_random_tiles
package vga_pkg;

  localparam int          H_DISPLAY_DEF = 1024;
  localparam int          V_DISPLAY_DEF = 768;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  // Galois form: shift right, fold the mask back in when a one drops out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_step16(input logic [15:0] x);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < 16; i++) begin
      v = lfsr_step(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/vga_lfsr16.sv
// rtl/vga_lfsr16.sv - 16-bit Galois LFSR register with seed load and step enable
module vga_lfsr16
  import vga_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= i_seed;
    end else if (i_step) begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/vga_random_tiles.sv
// rtl/vga_random_tiles.sv - random-colour tile pixel stage behind the VGA sync generator
// Optional pattern animation under VGA_RANDOM_ANIMATE_EN.
module vga_random_tiles
  import vga_pkg::*;
#(
  parameter int          H_DISPLAY = H_DISPLAY_DEF,
  parameter int          V_DISPLAY = V_DISPLAY_DEF,
  parameter int          TILE_LOG2 = 5,
  parameter int          CW        = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef VGA_RANDOM_ANIMATE_EN
  ,
  parameter int          FRAME_DIV = 30
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   hpos,
  input  logic [9:0]    vpos,
  input  logic          display_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          frame_tick
);

  localparam logic [10:0] H_END = 11'(H_DISPLAY);
  localparam logic [9:0]  V_END = 10'(V_DISPLAY);
  localparam int          TW    = 3 * CW;

  logic [10:0]   r_hpos;
  logic [9:0]    r_vpos;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_run;
  logic          w_origin;
  logic          w_line_start;
  logic          w_in_frame;
  logic          w_tile_end;
  logic          w_row_end;
  logic          w_frame_end;
  logic [15:0]   w_lfsr;
  logic [15:0]   r_row_seed;
  logic [15:0]   w_row_reload;
  logic [TW-1:0] w_tile;
  logic [CW-1:0] r_red;
  logic [CW-1:0] r_green;
  logic [CW-1:0] r_blue;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_tick;

  // Reset parks the position off-origin so a stale (0,0) cannot start a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos <= '1;
      r_vpos <= '1;
    end else begin
      r_hpos <= hpos;
      r_vpos <= vpos;
    end
  end

  assign w_origin     = (r_hpos == '0) && (r_vpos == '0);
  assign w_line_start = (r_hpos == '0);
  assign w_in_frame   = (r_vpos < V_END);
  assign w_tile_end   = (r_hpos < H_END) && w_in_frame && (&r_hpos[TILE_LOG2-1:0]);
  assign w_row_end    = (r_hpos == H_END) && w_in_frame && (&r_vpos[TILE_LOG2-1:0]);
  assign w_frame_end  = w_line_start && (r_vpos == V_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The origin cycle itself already counts as running, so pixel (0,0) is drawn.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    unique case (r_state)
      SYNC: begin
        if (w_origin) begin
          w_state_nxt = RUN;
          w_run       = 1'b1;
        end
      end
      RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_nxt = SYNC;
      end
    endcase
  end

`ifdef VGA_RANDOM_ANIMATE_EN
  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CNT_W-1:0] r_frame_cnt;
  logic [15:0]      r_frame_seed;
  logic [15:0]      w_frame_seed_nxt;
  logic             w_frame_wrap;

  assign w_frame_seed_nxt = lfsr_step16(r_frame_seed);
  assign w_frame_wrap     = (r_frame_cnt == CNT_W'(FRAME_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt  <= '0;
      r_frame_seed <= LFSR_SEED;
    end else if (w_run && w_frame_end) begin
      if (w_frame_wrap) begin
        r_frame_cnt  <= '0;
        r_frame_seed <= w_frame_seed_nxt;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // On a wrap the new seed is used straight away for the coming frame.
  assign w_row_reload = w_frame_wrap ? w_frame_seed_nxt : r_frame_seed;
`else
  assign w_row_reload = LFSR_SEED;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_seed <= LFSR_SEED;
    end else if (w_run) begin
      if (w_frame_end) begin
        r_row_seed <= w_row_reload;
      end else if (w_row_end) begin
        r_row_seed <= w_lfsr;
      end
    end
  end

  vga_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_run && w_line_start),
    .i_seed (r_row_seed),
    .i_step (w_run && w_tile_end),
    .o_q    (w_lfsr)
  );

  // The LFSR only picks up the row seed after hpos==0, so that pixel reads it directly.
  assign w_tile = w_line_start ? r_row_seed[TW-1:0] : w_lfsr[TW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_red        <= (w_run && display_on) ? w_tile[3*CW-1 -: CW] : '0;
      r_green      <= (w_run && display_on) ? w_tile[2*CW-1 -: CW] : '0;
      r_blue       <= (w_run && display_on) ? w_tile[CW-1:0]       : '0;
      r_hsync      <= hsync_in;
      r_vsync      <= vsync_in;
      r_frame_tick <= w_run && w_frame_end;
    end
  end

  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign hsync_out  = r_hsync;
  assign vsync_out  = r_vsync;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_random_tiles.sv
// tb/tb_vga_random_tiles.sv - self-checking bench for vga_random_tiles on a reduced 128x64 raster
module tb_vga_random_tiles;

  localparam int HD = 128;
  localparam int VD = 64;
  localparam int HT = 136;
  localparam int VT = 68;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef VGA_RANDOM_ANIMATE_EN
  localparam int FD = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hpos = '0;
  logic [9:0]  vpos = '0;
  logic        display_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [1:0]  red, green, blue;
  logic        hsync_out, vsync_out, frame_tick;

  always #5 clk = ~clk;

  vga_random_tiles #(
    .H_DISPLAY (HD),
    .V_DISPLAY (VD),
    .TILE_LOG2 (5),
    .CW        (2),
    .LFSR_SEED (SEED)
`ifdef VGA_RANDOM_ANIMATE_EN
    ,
    .FRAME_DIV (FD)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int          h0;
    int          h1;
    int          v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [5:0]  rgb;
  } vec_t;

  typedef struct {
    logic [8:0] exp;
    int         h;
    int         v;
  } sb_t;

  vec_t tab [11];
  sb_t  sb [$];

  int total = 0;
  int bad = 0;
  int frame_no = 0;
  int ticks [6];
  logic [5:0] cap0 [6];
  logic [5:0] cap32 = '0;

  logic        m_run = 1'b0;
  logic        m_pv = 1'b0;
  logic [15:0] m_show = SEED;
  logic [15:0] m_fseed = SEED;
  int          m_cnt = 0;
  int          p_h = 0;
  int          p_v = 0;
  logic        p_de = 1'b0;
  logic        p_hs = 1'b0;
  logic        p_vs = 1'b0;
  logic        p_tab = 1'b0;
  logic [5:0]  p_trgb = '0;

  function automatic logic [15:0] bstep(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [15:0] bstep_n(input logic [15:0] x, input int n);
    logic [15:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = bstep(y);
    return y;
  endfunction

  function automatic logic [5:0] tile(input int h, input int v, input logic [15:0] s);
    logic [15:0] y;
    y = bstep_n(s, (v / 32) * (HD / 32) + h / 32);
    return y[5:0];
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock: present position (h,v), side-band signals of the previous position.
  task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs,
                       input logic rst, input logic tb, input logic [5:0] trgb);
    logic       run_now;
    logic [5:0] rgb;
    logic       tk;
    logic [8:0] act;
    sb_t        e;
    run_now = m_run || (m_pv && p_h == 0 && p_v == 0);
    rgb = '0;
    tk = 1'b0;
    if (!rst) begin
      if (p_tab) rgb = p_trgb;
      else if (run_now && p_de) rgb = tile(p_h, p_v, m_show);
      tk = run_now && m_pv && p_h == 0 && p_v == VD;
      e.exp = {rgb, p_hs, p_vs, tk};
    end else begin
      e.exp = '0;
    end
    e.h = p_h;
    e.v = p_v;
    sb.push_back(e);
    if (rst) begin
      m_run = 1'b0;
      m_show = SEED;
      m_fseed = SEED;
      m_cnt = 0;
    end else begin
      m_run = run_now;
      if (tk) begin
`ifdef VGA_RANDOM_ANIMATE_EN
        if (m_cnt == FD - 1) begin
          m_fseed = bstep_n(m_fseed, 16);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        m_show = m_fseed;
`else
        m_show = SEED;
`endif
      end
    end
    hpos = 11'(h);
    vpos = 10'(v);
    display_on = p_de;
    hsync_in = p_hs;
    vsync_in = p_vs;
    reset = rst;
    m_pv = !rst;
    p_h = h;
    p_v = v;
    p_de = de;
    p_hs = hs;
    p_vs = vs;
    p_tab = tb;
    p_trgb = trgb;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    act = {red, green, blue, hsync_out, vsync_out, frame_tick};
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("FAIL pix h=%0d v=%0d got=%b want=%b", e.h, e.v, act, e.exp);
    end
    if (frame_tick === 1'b1) ticks[frame_no]++;
    if (e.h == 5 && e.v == 0) cap0[frame_no] = {red, green, blue};
    if (e.h == 5 && e.v == 32 && frame_no == 0) cap32 = {red, green, blue};
  endtask

  task automatic run_lines(input int v0, input int v1, input int rh, input int rv);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive(h, v, (h < HD) && (v < VD), (h >= 130) && (h <= 133), (v == 65) || (v == 66),
              (h == rh) && (v == rv), 1'b0, 6'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] f2;
    logic [5:0]  exp_f2;
`ifdef VGA_RANDOM_ANIMATE_EN
    f2 = bstep_n(SEED, 16);
`else
    f2 = SEED;
`endif
    exp_f2 = f2[5:0];
    for (int i = 0; i < 6; i++) begin
      ticks[i] = 0;
      cap0[i] = '0;
    end
    tab[0]  = '{100, 127, 20, 1'b1, 1'b0, 1'b0, 6'b000000};
    tab[1]  = '{128, 129, 20, 1'b0, 1'b0, 1'b0, 6'b000000};
    tab[2]  = '{130, 133, 20, 1'b0, 1'b1, 1'b0, 6'b000000};
    tab[3]  = '{134, 135, 20, 1'b0, 1'b0, 1'b0, 6'b000000};
    tab[4]  = '{0,   31,  0,  1'b1, 1'b0, 1'b0, 6'b100001};
    tab[5]  = '{32,  63,  0,  1'b1, 1'b0, 1'b0, 6'b110000};
    tab[6]  = '{64,  95,  0,  1'b1, 1'b0, 1'b0, 6'b111000};
    tab[7]  = '{96,  127, 0,  1'b1, 1'b0, 1'b0, 6'b011100};
    tab[8]  = '{128, 129, 0,  1'b0, 1'b0, 1'b0, 6'b000000};
    tab[9]  = '{130, 133, 0,  1'b0, 1'b1, 1'b0, 6'b000000};
    tab[10] = '{134, 135, 0,  1'b0, 1'b0, 1'b0, 6'b000000};

    for (int i = 0; i < 4; i++) drive(96 + i, 20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 11; i++) begin
      for (int h = tab[i].h0; h <= tab[i].h1; h++) begin
        drive(h, tab[i].v, tab[i].de, tab[i].hs, tab[i].vs, 1'b0, 1'b1, tab[i].rgb);
      end
    end
    run_lines(1, VT - 1, -1, -1);
    frame_no = 1;
    run_lines(0, VT - 1, -1, -1);
    frame_no = 2;
    run_lines(0, VT - 1, -1, -1);
    frame_no = 3;
    run_lines(0, VT - 1, 100, 30);
    frame_no = 4;
    run_lines(0, VT - 1, -1, -1);
    frame_no = 5;
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    check("ticks_f0", ticks[0], 1);
    check("ticks_f1", ticks[1], 1);
    check("ticks_f2", ticks[2], 1);
    check("ticks_f3_reset", ticks[3], 0);
    check("ticks_f4", ticks[4], 1);
    check("row1_first_tile", int'(cap32), int'(6'b001110));
    check("f0_first_tile", int'(cap0[0]), int'(6'b100001));
    check("f2_first_tile", int'(cap0[2]), int'(exp_f2));
    check("f4_after_reset", int'(cap0[4]), int'(6'b100001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
